// File: rtl/fpu_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fpu_seq
// Description : Multi-cycle floating-point add/subtract/multiply with
//               parametrised exponent/mantissa widths and exception flags.
// Revision    : 1.0  initial release
// ============================================================================
module fpu_seq #(
    parameter int  EXP_W = 8,
    parameter int  MAN_W = 23,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic [1:0]   control,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         overflow,
    output logic         underflow,
    output logic         invalid
);

    localparam int c_SW = MAN_W + 4;   // hidden + mantissa + 3 guard bits
    localparam int c_XW = EXP_W + 2;   // signed working exponent

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_UNPACK = 3'd1;
    localparam logic [2:0] c_ALIGN  = 3'd2;
    localparam logic [2:0] c_OP     = 3'd3;
    localparam logic [2:0] c_NORM   = 3'd4;
    localparam logic [2:0] c_PACK   = 3'd5;

    localparam logic [EXP_W-1:0]        c_EXP_ONES = {EXP_W{1'b1}};
    localparam logic signed [c_XW-1:0]  c_BIAS     = c_XW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [c_XW-1:0]  c_EMAX     = c_XW'((1 << EXP_W) - 1);
    localparam logic signed [c_XW-1:0]  c_XZERO    = '0;
    localparam logic signed [c_XW-1:0]  c_XONE     = c_XW'(1);
    localparam logic [W-1:0]            c_QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    logic [2:0]               r_state, w_next;
    logic [W-1:0]             r_a, r_b;
    logic [1:0]               r_ctl;
    logic                     r_spec, r_spec_inv;
    logic [W-1:0]             r_spec_res;
    logic                     r_mul, r_sa, r_sb;
    logic [EXP_W-1:0]         r_ea, r_eb;
    logic [MAN_W:0]           r_ma, r_mb;
    logic [c_SW-1:0]          r_sig_a, r_sig_b;
    logic signed [c_XW-1:0]   r_exp;
    logic                     r_sign, r_eff_sub, r_zero;
    logic [c_SW:0]            r_sig;
    logic [W-1:0]             r_result;
    logic                     r_ovf, r_unf, r_inv;

    // Operand decode (valid while in UNPACK)
    logic                     w_mul, w_sa, w_sb;
    logic [EXP_W-1:0]         w_ea, w_eb;
    logic [MAN_W-1:0]         w_fa, w_fb;
    logic                     w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;

    assign w_mul    = (r_ctl == 2'b01);
    assign w_sa     = r_a[W-1];
    assign w_sb     = r_b[W-1] ^ (r_ctl == 2'b10);
    assign w_ea     = r_a[W-2:MAN_W];
    assign w_eb     = r_b[W-2:MAN_W];
    assign w_fa     = r_a[MAN_W-1:0];
    assign w_fb     = r_b[MAN_W-1:0];
    assign w_a_zero = (w_ea == '0);
    assign w_b_zero = (w_eb == '0);
    assign w_a_inf  = (w_ea == c_EXP_ONES) && (w_fa == '0);
    assign w_b_inf  = (w_eb == c_EXP_ONES) && (w_fb == '0);
    assign w_a_nan  = (w_ea == c_EXP_ONES) && (w_fa != '0);
    assign w_b_nan  = (w_eb == c_EXP_ONES) && (w_fb != '0);

    logic         w_spec, w_spec_inv;
    logic [W-1:0] w_spec_res;

    always_comb begin
        w_spec     = 1'b1;
        w_spec_inv = 1'b0;
        w_spec_res = '0;
        if (w_a_nan || w_b_nan) begin
            w_spec_res = c_QNAN;
            w_spec_inv = 1'b1;
        end else if (w_mul) begin
            if ((w_a_inf && w_b_zero) || (w_a_zero && w_b_inf)) begin
                w_spec_res = c_QNAN;
                w_spec_inv = 1'b1;
            end else if (w_a_inf || w_b_inf) begin
                w_spec_res = {w_sa ^ w_sb, c_EXP_ONES, {MAN_W{1'b0}}};
            end else if (w_a_zero || w_b_zero) begin
                w_spec_res = {w_sa ^ w_sb, {(W-1){1'b0}}};
            end else begin
                w_spec = 1'b0;
            end
        end else begin
            if (w_a_inf && w_b_inf && (w_sa != w_sb)) begin
                w_spec_res = c_QNAN;
                w_spec_inv = 1'b1;
            end else if (w_a_inf) begin
                w_spec_res = {w_sa, c_EXP_ONES, {MAN_W{1'b0}}};
            end else if (w_b_inf) begin
                w_spec_res = {w_sb, c_EXP_ONES, {MAN_W{1'b0}}};
            end else if (w_b_zero) begin
                w_spec_res = w_a_zero ? {w_sa, {(W-1){1'b0}}} : r_a;
            end else if (w_a_zero) begin
                w_spec_res = {w_sb, r_b[W-2:0]};
            end else begin
                w_spec = 1'b0;
            end
        end
    end

    // Alignment: larger magnitude first, smaller shifted right in one step
    logic                 w_a_big;
    logic [EXP_W-1:0]     w_e_big, w_e_small, w_diff;
    logic [MAN_W:0]       w_m_big, w_m_small;
    logic [c_SW-1:0]      w_small_sh;

    assign w_a_big    = ({r_ea, r_ma} >= {r_eb, r_mb});
    assign w_e_big    = w_a_big ? r_ea : r_eb;
    assign w_e_small  = w_a_big ? r_eb : r_ea;
    assign w_m_big    = w_a_big ? r_ma : r_mb;
    assign w_m_small  = w_a_big ? r_mb : r_ma;
    assign w_diff     = w_e_big - w_e_small;
    assign w_small_sh = (int'(w_diff) >= c_SW) ? '0 : ({w_m_small, 3'b000} >> w_diff);

    logic [2*MAN_W+1:0] w_prod;
    assign w_prod = {{(MAN_W+1){1'b0}}, r_sig_a[c_SW-1:3]} * {{(MAN_W+1){1'b0}}, r_sig_b[c_SW-1:3]};

    // Packing of the final value (used in the PACK cycle)
    logic [W-1:0] w_pack_res;
    logic         w_pack_ovf, w_pack_unf, w_pack_inv;

    always_comb begin
        w_pack_res = '0;
        w_pack_ovf = 1'b0;
        w_pack_unf = 1'b0;
        w_pack_inv = 1'b0;
        if (r_spec) begin
            w_pack_res = r_spec_res;
            w_pack_inv = r_spec_inv;
        end else if (r_zero) begin
            w_pack_res = '0;
        end else if (r_exp >= c_EMAX) begin
            w_pack_res = {r_sign, c_EXP_ONES, {MAN_W{1'b0}}};
            w_pack_ovf = 1'b1;
        end else if (r_exp <= c_XZERO) begin
            w_pack_res = {r_sign, {(W-1){1'b0}}};
            w_pack_unf = 1'b1;
        end else begin
            w_pack_res = {r_sign, r_exp[EXP_W-1:0], r_sig[c_SW-2:3]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:   if (start) w_next = c_UNPACK;
            c_UNPACK: w_next = c_ALIGN;
            // specials are classified in UNPACK and skip the arithmetic path
            c_ALIGN:  w_next = r_spec ? c_PACK : c_OP;
            c_OP:     w_next = c_NORM;
            c_NORM:   if ((r_sig == '0) || r_sig[c_SW] || r_sig[c_SW-1]) w_next = c_PACK;
            c_PACK:   w_next = c_IDLE;
            default:  w_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    r_a   <= A;
                    r_b   <= B;
                    r_ctl <= control;
                end
            end
            c_UNPACK: begin
                r_spec     <= w_spec;
                r_spec_inv <= w_spec_inv;
                r_spec_res <= w_spec_res;
                r_mul      <= w_mul;
                r_sa       <= w_sa;
                r_sb       <= w_sb;
                r_ea       <= w_ea;
                r_eb       <= w_eb;
                r_ma       <= {1'b1, w_fa};
                r_mb       <= {1'b1, w_fb};
                r_zero     <= 1'b0;
            end
            c_ALIGN: begin
                if (r_mul) begin
                    r_exp   <= $signed({2'b00, r_ea}) + $signed({2'b00, r_eb}) - c_BIAS;
                    r_sign  <= r_sa ^ r_sb;
                    r_sig_a <= {r_ma, 3'b000};
                    r_sig_b <= {r_mb, 3'b000};
                end else begin
                    r_exp     <= $signed({2'b00, w_e_big});
                    r_sign    <= w_a_big ? r_sa : r_sb;
                    r_eff_sub <= r_sa ^ r_sb;
                    r_sig_a   <= {w_m_big, 3'b000};
                    r_sig_b   <= w_small_sh;
                end
            end
            c_OP: begin
                if (r_mul) begin
                    // low product bits collapse into a sticky LSB below the kept field
                    r_sig <= {w_prod[2*MAN_W+1 -: c_SW], |w_prod[MAN_W-3:0]};
                end else if (r_eff_sub) begin
                    r_sig <= {1'b0, r_sig_a} - {1'b0, r_sig_b};
                end else begin
                    r_sig <= {1'b0, r_sig_a} + {1'b0, r_sig_b};
                end
            end
            c_NORM: begin
                if (r_sig == '0) begin
                    r_zero <= 1'b1;
                end else if (r_sig[c_SW]) begin
                    r_sig <= r_sig >> 1;
                    r_exp <= r_exp + c_XONE;
                end else if (!r_sig[c_SW-1]) begin
                    r_sig <= r_sig << 1;
                    r_exp <= r_exp - c_XONE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
            r_inv    <= 1'b0;
        end else if ((r_state == c_IDLE) && start) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
            r_inv <= 1'b0;
        end else if (r_state == c_PACK) begin
            r_result <= w_pack_res;
            r_ovf    <= w_pack_ovf;
            r_unf    <= w_pack_unf;
            r_inv    <= w_pack_inv;
        end
    end

    assign busy      = (r_state == c_UNPACK) || (r_state == c_ALIGN) ||
                       (r_state == c_OP)     || (r_state == c_NORM);
    assign done      = (r_state == c_PACK);
    assign result    = done ? w_pack_res : r_result;
    assign overflow  = done ? w_pack_ovf : r_ovf;
    assign underflow = done ? w_pack_unf : r_unf;
    assign invalid   = done ? w_pack_inv : r_inv;

endmodule
`default_nettype wire

// File: tb/tb_fpu_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fpu_seq
// Description : Scoreboard bench for fpu_seq, single and half-size formats.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fpu_seq;

    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    logic        s32_start, busy32, done32, ovf32, unf32, inv32;
    logic [31:0] s32_a, s32_b, res32;
    logic [1:0]  s32_ctl;
    logic        s16_start, busy16, done16, ovf16, unf16, inv16;
    logic [15:0] s16_a, s16_b, res16;
    logic [1:0]  s16_ctl;

    fpu_seq #(.EXP_W(8), .MAN_W(23)) u_dut32 (
        .clk(clk), .reset(reset), .start(s32_start), .A(s32_a), .B(s32_b),
        .control(s32_ctl), .busy(busy32), .done(done32), .result(res32),
        .overflow(ovf32), .underflow(unf32), .invalid(inv32)
    );

    fpu_seq #(.EXP_W(5), .MAN_W(10)) u_dut16 (
        .clk(clk), .reset(reset), .start(s16_start), .A(s16_a), .B(s16_b),
        .control(s16_ctl), .busy(busy16), .done(done16), .result(res16),
        .overflow(ovf16), .underflow(unf16), .invalid(inv16)
    );

    typedef struct {
        logic [31:0] res;
        logic [2:0]  flg;   // {overflow, underflow, invalid}
        int          t0;
        int          lat;
    } exp_t;

    exp_t q32[$];
    exp_t q16[$];
    exp_t m32_e, m16_e;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (done32) begin
            check("busy_low_at_done32", 32'(busy32), 32'd0);
            if (q32.size() == 0) begin
                check("unexpected_done32", 32'd1, 32'd0);
            end else begin
                m32_e = q32.pop_front();
                check("result32", res32, m32_e.res);
                check("flags32", 32'({ovf32, unf32, inv32}), 32'(m32_e.flg));
                check("latency32", 32'(cyc - m32_e.t0), 32'(m32_e.lat));
            end
        end
    end

    always @(negedge clk) begin
        if (done16) begin
            check("busy_low_at_done16", 32'(busy16), 32'd0);
            if (q16.size() == 0) begin
                check("unexpected_done16", 32'd1, 32'd0);
            end else begin
                m16_e = q16.pop_front();
                check("result16", 32'(res16), m16_e.res);
                check("flags16", 32'({ovf16, unf16, inv16}), 32'(m16_e.flg));
                check("latency16", 32'(cyc - m16_e.t0), 32'(m16_e.lat));
            end
        end
    end

    task automatic issue(input bit w16, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] ctl, input logic [31:0] res,
                         input logic [2:0] flg, input int lat);
        exp_t e;
        @(negedge clk);
        e.res = res;
        e.flg = flg;
        e.t0  = cyc;
        e.lat = lat;
        if (w16) begin
            s16_a = a[15:0]; s16_b = b[15:0]; s16_ctl = ctl; s16_start = 1'b1;
            q16.push_back(e);
        end else begin
            s32_a = a; s32_b = b; s32_ctl = ctl; s32_start = 1'b1;
            q32.push_back(e);
        end
        @(negedge clk);
        s32_start = 1'b0;
        s16_start = 1'b0;
        check(w16 ? "busy_after_start16" : "busy_after_start32",
              32'(w16 ? busy16 : busy32), 32'd1);
    endtask

    task automatic wait_done(input bit w16);
        int n = 0;
        while (((w16 ? done16 : done32) == 1'b0) && (n < 64)) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic run(input bit w16, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] ctl, input logic [31:0] res,
                       input logic [2:0] flg, input int lat);
        issue(w16, a, b, ctl, res, flg, lat);
        wait_done(w16);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        s32_start = 1'b0; s32_a = '0; s32_b = '0; s32_ctl = 2'b00;
        s16_start = 1'b0; s16_a = '0; s16_b = '0; s16_ctl = 2'b00;
        repeat (3) @(negedge clk);
        check("reset_result32", res32, 32'h0);
        check("reset_ctl32", 32'({busy32, done32, ovf32, unf32, inv32}), 32'd0);
        check("reset_ctl16", 32'({busy16, done16, ovf16, unf16, inv16, res16}), 32'd0);
        reset = 1'b0;

        // Each run starts in the cycle after the previous done (back-to-back)
        run(0, 32'h3FC00000, 32'h40100000, 2'b00, 32'h40700000, 3'b000, 5);
        run(0, 32'h3F800000, 32'h3F400000, 2'b10, 32'h3E800000, 3'b000, 7);
        run(0, 32'h3F800000, 32'h3F800000, 2'b10, 32'h00000000, 3'b000, 5);
        run(0, 32'h3FC00000, 32'h40100000, 2'b01, 32'h40580000, 3'b000, 5);
        run(0, 32'h41400000, 32'h3F000000, 2'b01, 32'h40C00000, 3'b000, 5);
        run(0, 32'h7F000000, 32'h7F000000, 2'b01, 32'h7F800000, 3'b100, 5);
        run(0, 32'h00800000, 32'h00800000, 2'b01, 32'h00000000, 3'b010, 5);
        run(0, 32'h7FC00000, 32'h3F800000, 2'b00, 32'h7FC00000, 3'b001, 3);
        run(0, 32'h7F800000, 32'h7F800000, 2'b10, 32'h7FC00000, 3'b001, 3);
        run(0, 32'h3FC00000, 32'h3FC00000, 2'b11, 32'h40400000, 3'b000, 5);
        run(0, 32'h3FC00000, 32'h00000000, 2'b00, 32'h3FC00000, 3'b000, 3);
        run(0, 32'h00000000, 32'h7F800000, 2'b01, 32'h7FC00000, 3'b001, 3);
        run(0, 32'hBF800000, 32'h7F800000, 2'b01, 32'hFF800000, 3'b000, 3);
        run(0, 32'h40000000, 32'h40400000, 2'b10, 32'hBF800000, 3'b000, 6);
        run(0, 32'h4B800000, 32'h3F800000, 2'b00, 32'h4B800000, 3'b000, 5);
        run(0, 32'h4E800000, 32'h3F800000, 2'b00, 32'h4E800000, 3'b000, 5);

        // start held high while busy and through the done cycle is ignored
        issue(0, 32'h3FC00000, 32'h40100000, 2'b00, 32'h40700000, 3'b000, 5);
        s32_a = 32'h41400000; s32_b = 32'h41400000; s32_ctl = 2'b01; s32_start = 1'b1;
        repeat (5) @(negedge clk);
        s32_start = 1'b0;
        repeat (8) @(negedge clk);

        // reset three cycles into an operation aborts it without a done
        s32_a = 32'h3FC00000; s32_b = 32'h40100000; s32_ctl = 2'b01; s32_start = 1'b1;
        @(negedge clk);
        s32_start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_result32", res32, 32'h0);
        check("abort_ctl32", 32'({busy32, done32, ovf32, unf32, inv32}), 32'd0);
        reset = 1'b0;
        repeat (8) @(negedge clk);

        run(0, 32'h3FC00000, 32'h40100000, 2'b01, 32'h40580000, 3'b000, 5);
        run(1, 32'h00003E00, 32'h00004080, 2'b00, 32'h00004380, 3'b000, 5);
        run(1, 32'h00003E00, 32'h00004080, 2'b01, 32'h000042C0, 3'b000, 5);

        repeat (5) @(negedge clk);
        check("queue32_drained", 32'(q32.size()), 32'd0);
        check("queue16_drained", 32'(q16.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
